// File: rtl/banked_ram_pkg.sv
// Shared types and helpers for banked_sync_ram: FSM state encoding, byte count
// and the per-byte even-parity function.
package banked_ram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int BITS_PER_BYTE = 8;

    function automatic int byte_count(input int data_width);
        return data_width / BITS_PER_BYTE;
    endfunction

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/banked_sync_ram_if.sv
// Request/response bus of banked_sync_ram; master drives requests, slave is the RAM.
interface banked_sync_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic                    cs;
    logic                    we;
    logic                    oe;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rvalid;
    logic                    ready;
    logic                    parity_err;

    modport master (
        output cs, we, oe, be, addr, wdata,
        input  rdata, rvalid, ready, parity_err
    );

    modport slave (
        input  cs, we, oe, be, addr, wdata,
        output rdata, rvalid, ready, parity_err
    );

endinterface

// File: rtl/banked_ram_rd_pipe.sv
// READ_LATENCY-deep read response pipeline carrying valid, oe, data and (with
// BANKED_RAM_PARITY_EN) stored parity; only the valid bits are reset.
module banked_ram_rd_pipe
    import banked_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vld,
    input  logic                    i_oe,
    input  logic [DATA_WIDTH-1:0]   i_data,
`ifdef BANKED_RAM_PARITY_EN
    input  logic [DATA_WIDTH/8-1:0] i_par,
    output logic                    o_perr,
`endif
    output logic                    o_vld,
    output logic [DATA_WIDTH-1:0]   o_data
);
    localparam int LAST = READ_LATENCY - 1;

    logic                  r_vld  [READ_LATENCY];
    logic                  r_oe   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] r_data [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) r_vld[i] <= 1'b0;
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < READ_LATENCY; i++) r_vld[i] <= r_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        r_oe[0]   <= i_oe;
        r_data[0] <= i_data;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_oe[i]   <= r_oe[i-1];
            r_data[i] <= r_data[i-1];
        end
    end

    // Data is gated by valid so rdata reads 0 between beats and out of reset.
    assign o_vld  = r_vld[LAST];
    assign o_data = (r_vld[LAST] && r_oe[LAST]) ? r_data[LAST] : '0;

`ifdef BANKED_RAM_PARITY_EN
    localparam int BYTES = byte_count(DATA_WIDTH);

    logic [BYTES-1:0] r_par [READ_LATENCY];
    logic [BYTES-1:0] w_par_calc;

    always_ff @(posedge clk) begin
        r_par[0] <= i_par;
        for (int i = 1; i < READ_LATENCY; i++) r_par[i] <= r_par[i-1];
    end

    always_comb begin
        w_par_calc = '0;
        for (int b = 0; b < BYTES; b++) w_par_calc[b] = byte_parity(r_data[LAST][8*b +: 8]);
    end

    // Checked on the raw word, so a corrupted byte is flagged even with oe=0.
    assign o_perr = r_vld[LAST] && (w_par_calc != r_par[LAST]);
`endif

endmodule

// File: rtl/banked_sync_ram.sv
// banked_sync_ram: byte-enabled synchronous RAM with hardware zero-init after reset,
// READ_LATENCY read pipeline and ready handshake. BANKED_RAM_PARITY_EN adds byte parity.
module banked_sync_ram
    import banked_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    banked_sync_ram_if.slave bus
);
    localparam int BYTES = byte_count(DATA_WIDTH);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]    CNT_LAST  = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "banked_sync_ram: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $fatal(1, "banked_sync_ram: DATA_WIDTH must be a multiple of 8");
    end
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
        $fatal(1, "banked_sync_ram: DEPTH exceeds 2**ADDR_WIDTH");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic               w_ready;
    logic               w_init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT && r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_cnt == CNT_LAST) w_state_nxt = ST_RUN;
    end

    always_comb begin
        w_ready = (r_state == ST_RUN);
        w_init  = (r_state == ST_INIT);
    end

    logic                  w_accept;
    logic                  w_in_range;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_mem_we;
    logic [BYTES-1:0]      w_mem_be;
    logic [IDX_W-1:0]      w_mem_idx;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_rd_fire;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_accept   = bus.cs && w_ready;
    assign w_in_range = {1'b0, bus.addr} < DEPTH_EXT;
    assign w_idx      = bus.addr[IDX_W-1:0];

    // INIT owns the write port; bus writes only land in RUN and in range.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_be    = '0;
        w_mem_idx   = w_idx;
        w_mem_wdata = bus.wdata;
        if (w_init) begin
            w_mem_we    = 1'b1;
            w_mem_be    = '1;
            w_mem_idx   = r_cnt;
            w_mem_wdata = '0;
        end else if (w_accept && bus.we && w_in_range) begin
            w_mem_we = 1'b1;
            w_mem_be = bus.be;
        end
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_mem_be[i]) r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
            end
        end
    end

    assign w_rd_fire = w_accept && !bus.we;
    assign w_rd_data = w_in_range ? r_mem[w_idx] : '0;

`ifdef BANKED_RAM_PARITY_EN
    logic [BYTES-1:0] r_par [DEPTH];
    logic [BYTES-1:0] w_mem_par;
    logic [BYTES-1:0] w_rd_par;

    always_comb begin
        w_mem_par = '0;
        for (int i = 0; i < BYTES; i++) w_mem_par[i] = byte_parity(w_mem_wdata[8*i +: 8]);
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (w_mem_be[i]) r_par[w_mem_idx][i] <= w_mem_par[i];
            end
        end
    end

    // Out-of-range reads carry zero data with zero parity, so they never flag.
    assign w_rd_par = w_in_range ? r_par[w_idx] : '0;
`endif

    banked_ram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (w_rd_fire),
        .i_oe   (bus.oe),
        .i_data (w_rd_data),
`ifdef BANKED_RAM_PARITY_EN
        .i_par  (w_rd_par),
        .o_perr (bus.parity_err),
`endif
        .o_vld  (bus.rvalid),
        .o_data (bus.rdata)
    );

`ifndef BANKED_RAM_PARITY_EN
    assign bus.parity_err = 1'b0;
`endif

    assign bus.ready = w_ready;

endmodule
